// File: rtl/clock_set_ctrl_pkg.sv
// Shared field limits, widths and FSM state type for the time-of-day setter.
package clock_set_ctrl_pkg;

  localparam int unsigned HOURS_W   = 5;
  localparam int unsigned MINUTES_W = 6;
  localparam int unsigned SECONDS_W = 6;

  localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
  localparam logic [MINUTES_W-1:0] MINUTES_MAX = 6'd59;
  localparam logic [SECONDS_W-1:0] SECONDS_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Strobes, debounced buttons and time-of-day outputs of the clock setter.
interface clock_set_ctrl_if;
  import clock_set_ctrl_pkg::*;

  logic                 i_1hz_stb;
  logic                 i_slow_set_stb;
  logic                 i_fast_set_stb;
  logic                 i_fast_set_db;
  logic                 i_set_hours_db;
  logic                 i_set_minutes_db;
  logic [HOURS_W-1:0]   o_hours;
  logic [MINUTES_W-1:0] o_minutes;
  logic [SECONDS_W-1:0] o_seconds;
  logic                 o_setting;

  modport slave (
    input  i_1hz_stb, i_slow_set_stb, i_fast_set_stb,
    input  i_fast_set_db, i_set_hours_db, i_set_minutes_db,
    output o_hours, o_minutes, o_seconds, o_setting
  );

  modport master (
    output i_1hz_stb, i_slow_set_stb, i_fast_set_stb,
    output i_fast_set_db, i_set_hours_db, i_set_minutes_db,
    input  o_hours, o_minutes, o_seconds, o_setting
  );
endinterface

// File: rtl/clock_set_ctrl_mod_counter.sv
// Modulo-(MAX+1) counter with clear; carry flags an increment taken at MAX.
module mod_counter #(
  parameter int unsigned       WIDTH = 6,
  parameter logic [WIDTH-1:0]  MAX   = WIDTH'(59)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carry
);

  logic [WIDTH-1:0] count_q;

  assign o_count = count_q;
  assign o_carry = i_inc & (count_q == MAX);

  // Clear has priority over increment; wrap to zero after MAX.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else if (i_clr) begin
      count_q <= '0;
    end else if (i_inc) begin
      count_q <= (count_q == MAX) ? '0 : count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day registers with 1 Hz advance and press/auto-repeat setting.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_STB = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  clock_set_ctrl_if.slave  bus
);

  localparam int unsigned    HW       = (HOLD_STB > 0) ? $clog2(HOLD_STB + 1) : 1;
  localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_STB);

  state_t          state_q;
  logic [HW-1:0]   hold_q;
  logic            prev_h_q, prev_m_q;
  logic            setting_q;

  logic rise_h, rise_m, any_rise, any_btn, rate_stb, hold_done, repeat_stb;
  logic sec_inc, sec_clr, min_inc, hr_inc;
  logic sec_carry, min_carry, hr_carry_unused;

  // Edge detect, rate selection and per-field increment decode.
  // Set-mode increments never see a seconds carry (seconds only tick in IDLE
  // without a concurrent press), so minutes/hours wrap independently there.
  always_comb begin
    rise_h     = bus.i_set_hours_db & ~prev_h_q;
    rise_m     = bus.i_set_minutes_db & ~prev_m_q;
    any_rise   = rise_h | rise_m;
    any_btn    = bus.i_set_hours_db | bus.i_set_minutes_db;
    rate_stb   = bus.i_fast_set_db ? bus.i_fast_set_stb : bus.i_slow_set_stb;
    hold_done  = (hold_q == HOLD_MAX);
    repeat_stb = (state_q == ST_HOLD) & ~any_rise & any_btn & rate_stb & hold_done;
    sec_inc    = (state_q == ST_IDLE) & ~any_rise & bus.i_1hz_stb;
    sec_clr    = any_rise;
    min_inc    = rise_m | (repeat_stb & bus.i_set_minutes_db) | sec_carry;
    hr_inc     = rise_h | (repeat_stb & bus.i_set_hours_db) | (sec_carry & min_carry);
  end

  // Press/hold state machine, hold-off counter and button history.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      prev_h_q  <= 1'b0;
      prev_m_q  <= 1'b0;
      setting_q <= 1'b0;
    end else begin
      prev_h_q <= bus.i_set_hours_db;
      prev_m_q <= bus.i_set_minutes_db;
      if (any_rise) begin
        state_q   <= ST_PRESS;
        hold_q    <= '0;
        setting_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            setting_q <= 1'b0;
          end
          ST_PRESS: begin
            state_q   <= any_btn ? ST_HOLD : ST_IDLE;
            setting_q <= any_btn;
          end
          ST_HOLD: begin
            if (!any_btn) begin
              state_q   <= ST_IDLE;
              setting_q <= 1'b0;
            end else if (rate_stb && !hold_done) begin
              hold_q <= hold_q + HW'(1);
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            setting_q <= 1'b0;
          end
        endcase
      end
    end
  end

  mod_counter #(.WIDTH(SECONDS_W), .MAX(SECONDS_MAX)) u_sec (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(sec_inc), .i_clr(sec_clr),
    .o_count(bus.o_seconds), .o_carry(sec_carry)
  );

  mod_counter #(.WIDTH(MINUTES_W), .MAX(MINUTES_MAX)) u_min (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(min_inc), .i_clr(1'b0),
    .o_count(bus.o_minutes), .o_carry(min_carry)
  );

  mod_counter #(.WIDTH(HOURS_W), .MAX(HOURS_MAX)) u_hr (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(hr_inc), .i_clr(1'b0),
    .o_count(bus.o_hours), .o_carry(hr_carry_unused)
  );

  assign bus.o_setting = setting_q;

endmodule
